// File: rtl/lcd_view_scheduler.sv
// Frame sequencer for the 4-bit debug LCD writer: snapshots a RAM or CPU view, requests a frame, dwells, advances the page.
// Define LCD_VIEW_SCHED_TIMEOUT_EN to add the frame watchdog and the sticky frame_err flag.
module lcd_view_scheduler #(
  parameter int NUM_REGS       = 10,
  parameter int DWELL_CYCLES   = 12000000,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic                  qzt_clk,
  input  logic                  rst_n,
  input  logic                  switchFlag,
  input  logic                  auto_en,
  input  logic                  step_btn,
  input  logic [8*NUM_REGS-1:0] CPU_interface,
  input  logic [7:0]            ram_addr,
  input  logic [7:0]            ram_data,
  input  logic                  lcd_ready,
  input  logic                  frame_done,
  output logic [3:0]            dbg_reg_addr,
  output logic [7:0]            addrOut,
  output logic [7:0]            dataOut,
  output logic                  frame_req,
  output logic                  view_mode,
  output logic                  frame_err
);

  typedef enum logic [2:0] {WAIT_READY, LATCH, REQ, WAIT_DONE, DWELL} state_t;

  localparam logic [23:0] DWELL_LOAD = 24'(DWELL_CYCLES - 1);
  localparam logic [3:0]  LAST_PAGE  = 4'(NUM_REGS - 1);

  state_t                 state;
  logic [23:0]            dwell_cnt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   step_prev;
  logic                   pending;
  logic                   step_edge;
  logic                   view_changed;
  logic [3:0]             next_page;
  logic [7:0]             cur_byte;

  assign step_edge    = sync_q[SYNC_STAGES-1] & ~step_prev;
  assign view_changed = switchFlag != view_mode;
  assign next_page    = (dbg_reg_addr == LAST_PAGE) ? 4'd0 : dbg_reg_addr + 4'd1;
  assign cur_byte     = CPU_interface[8*int'(dbg_reg_addr) +: 8];

`ifdef LCD_VIEW_SCHED_TIMEOUT_EN
  localparam logic [21:0] TIMEOUT_LAST = 22'(TIMEOUT_CYCLES - 1);
  logic [21:0] wd_cnt;
`else
  assign frame_err = 1'b0;
`endif

  // NOTE: every register here, including the synchroniser, is on the async
  // reset so a reset mid-frame drops frame_req without waiting for a clock.
  always_ff @(posedge qzt_clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= WAIT_READY;
      dbg_reg_addr <= 4'd0;
      addrOut      <= 8'd0;
      dataOut      <= 8'd0;
      frame_req    <= 1'b0;
      view_mode    <= 1'b0;
      dwell_cnt    <= 24'd0;
      sync_q       <= '0;
      step_prev    <= 1'b0;
      pending      <= 1'b0;
`ifdef LCD_VIEW_SCHED_TIMEOUT_EN
      wd_cnt       <= 22'd0;
      frame_err    <= 1'b0;
`endif
    end else begin
      sync_q    <= SYNC_STAGES'({sync_q, step_btn});
      step_prev <= sync_q[SYNC_STAGES-1];

      // Edges collapse into one pending step; RAM view discards them.
      if (switchFlag)     pending <= 1'b0;
      else if (step_edge) pending <= 1'b1;

      if (!lcd_ready && state != WAIT_READY) begin
        frame_req <= 1'b0;
        state     <= WAIT_READY;
      end else begin
        case (state)
          WAIT_READY: begin
            if (pending && !switchFlag) begin
              dbg_reg_addr <= next_page;
              pending      <= 1'b0;
            end
            if (lcd_ready) state <= LATCH;
          end

          LATCH: begin
            view_mode <= switchFlag;
            if (switchFlag) begin
              addrOut <= ram_addr;
              dataOut <= ram_data;
            end else begin
              addrOut <= {4'h0, dbg_reg_addr};
              dataOut <= cur_byte;
            end
            frame_req <= 1'b1;
            state     <= REQ;
          end

          REQ: begin
`ifdef LCD_VIEW_SCHED_TIMEOUT_EN
            wd_cnt <= 22'd0;
`endif
            state <= WAIT_DONE;
          end

          WAIT_DONE: begin
            if (frame_done) begin
              frame_req <= 1'b0;
              dwell_cnt <= DWELL_LOAD;
              state     <= DWELL;
            end
`ifdef LCD_VIEW_SCHED_TIMEOUT_EN
            else if (wd_cnt == TIMEOUT_LAST) begin
              frame_err <= 1'b1;
              frame_req <= 1'b0;
              dwell_cnt <= DWELL_LOAD;
              state     <= DWELL;
            end else begin
              wd_cnt <= wd_cnt + 22'd1;
            end
`endif
          end

          DWELL: begin
            if (view_changed) begin
              dbg_reg_addr <= 4'd0;
              state        <= LATCH;
            end else if (pending && !switchFlag) begin
              // A step that coincides with dwell expiry still advances only once.
              dbg_reg_addr <= next_page;
              pending      <= 1'b0;
              state        <= LATCH;
            end else if (dwell_cnt == 24'd0) begin
              if (auto_en && !view_mode) dbg_reg_addr <= next_page;
              state <= LATCH;
            end else begin
              dwell_cnt <= dwell_cnt - 24'd1;
            end
          end

          default: state <= WAIT_READY;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lcd_view_scheduler.sv
// Bench for lcd_view_scheduler: acts as the LCD writer and checks every snapshot against a page-level model.
module tb_lcd_view_scheduler;

  localparam int NREG  = 10;
  localparam int DWELL = 8;
  localparam int TMO   = 16;

  logic        qzt_clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        switchFlag = 1'b0;
  logic        auto_en = 1'b0;
  logic        step_btn = 1'b0;
  logic        lcd_ready = 1'b0;
  logic        frame_done = 1'b0;
  logic [79:0] cpu_bus;
  logic [7:0]  ram_addr;
  logic [7:0]  ram_data;
  logic [3:0]  dbg_reg_addr;
  logic [7:0]  addrOut;
  logic [7:0]  dataOut;
  logic        frame_req;
  logic        view_mode;
  logic        frame_err;

  int vectors = 0;
  int miscompares = 0;
  int page = 0;

  lcd_view_scheduler #(
    .NUM_REGS(NREG), .DWELL_CYCLES(DWELL), .SYNC_STAGES(2), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .qzt_clk(qzt_clk), .rst_n(rst_n), .switchFlag(switchFlag), .auto_en(auto_en),
    .step_btn(step_btn), .CPU_interface(cpu_bus), .ram_addr(ram_addr), .ram_data(ram_data),
    .lcd_ready(lcd_ready), .frame_done(frame_done), .dbg_reg_addr(dbg_reg_addr),
    .addrOut(addrOut), .dataOut(dataOut), .frame_req(frame_req), .view_mode(view_mode),
    .frame_err(frame_err)
  );

  always #5 qzt_clk = ~qzt_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic randomize_taps();
    cpu_bus         = {$urandom(), $urandom(), $urandom()};
    cpu_bus[79:72]  = 8'hA5;
    ram_addr        = 8'($urandom());
    ram_data        = 8'($urandom());
  endtask

  // Counts cycles until frame_req is seen high, bounded.
  task automatic wait_req(output int n);
    n = 0;
    do begin
      @(negedge qzt_clk);
      n++;
    end while (!frame_req && n < 200);
    check("req_rise", frame_req, 1);
  endtask

  // Checks the snapshot, disturbs the taps, optionally presses step, then completes the frame.
  task automatic serve(input int delay, input int presses, input logic view, input logic zero_taps);
    logic [7:0] ea;
    logic [7:0] ed;
    ea = view ? ram_addr : 8'(page);
    ed = view ? ram_data : cpu_bus[8*page +: 8];
    check("page", dbg_reg_addr, page);
    check("view", view_mode, view);
    check("addr", addrOut, ea);
    check("data", dataOut, ed);
    if (zero_taps) begin
      ram_addr = 8'h00;
      ram_data = 8'h00;
    end else begin
      randomize_taps();
    end
    for (int p = 0; p < presses; p++) begin
      step_btn = 1'b1;
      repeat (2) @(negedge qzt_clk);
      step_btn = 1'b0;
      repeat (2) @(negedge qzt_clk);
    end
    repeat (delay) @(negedge qzt_clk);
    check("frozen_addr", addrOut, ea);
    check("frozen_data", dataOut, ed);
    check("req_held", frame_req, 1);
    frame_done = 1'b1;
    @(negedge qzt_clk);
    frame_done = 1'b0;
    check("req_drop", frame_req, 0);
  endtask

  initial begin
    int n;
    int pat[7];
    pat = '{1, 1, 1, 1, 2, 0, 1};
    randomize_taps();
    #1 rst_n = 1'b0;
    repeat (3) @(negedge qzt_clk);
    check("rst_page", dbg_reg_addr, 0);
    check("rst_addr", addrOut, 0);
    check("rst_data", dataOut, 0);
    check("rst_req", frame_req, 0);
    check("rst_view", view_mode, 0);
    check("rst_err", frame_err, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge qzt_clk);
    check("idle_not_ready", frame_req, 0);

    // CPU view, auto advance through the wrap.
    auto_en   = 1'b1;
    lcd_ready = 1'b1;
    page      = 0;
    wait_req(n);
    for (int i = 0; i < 12; i++) begin
      serve(int'($urandom_range(1, 4)), 0, 1'b0, 1'b0);
      page = (page + 1) % NREG;
      wait_req(n);
      check("gap_auto", n, DWELL + 1);
    end

    // Reset in the middle of a frame.
    @(negedge qzt_clk);
    #2 rst_n = 1'b0;
    #1 check("rst_async_req", frame_req, 0);
    lcd_ready = 1'b0;
    auto_en   = 1'b0;
    @(negedge qzt_clk);
    check("rst2_page", dbg_reg_addr, 0);
    check("rst2_data", dataOut, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge qzt_clk);
    check("rst2_idle", frame_req, 0);
    page      = 0;
    lcd_ready = 1'b1;
    wait_req(n);

    // Manual stepping; several presses in one frame give a single advance.
    for (int i = 0; i < 7; i++) begin
      serve(int'($urandom_range(1, 4)), pat[i], 1'b0, 1'b0);
      if (pat[i] > 0) page = (page + 1) % NREG;
      wait_req(n);
      check("gap_step", n, (pat[i] > 0) ? 2 : DWELL + 1);
    end

    // Switch to RAM view during the dwell of page 6.
    serve(2, 0, 1'b0, 1'b0);
    @(negedge qzt_clk);
    switchFlag = 1'b1;
    ram_addr   = 8'h3C;
    ram_data   = 8'h7E;
    @(negedge qzt_clk);
    check("switch_page0", dbg_reg_addr, 0);
    check("switch_req_low", frame_req, 0);
    @(negedge qzt_clk);
    check("switch_view", view_mode, 1);
    page = 0;
    wait_req(n);
    check("switch_gap", n, 1);

    // RAM snapshot holds while the taps move, then picks up the new values.
    serve(3, 0, 1'b1, 1'b1);
    wait_req(n);
    check("gap_ram", n, DWELL + 1);
    for (int i = 0; i < 3; i++) begin
      serve(int'($urandom_range(1, 4)), (i == 1) ? 1 : 0, 1'b1, 1'b0);
      wait_req(n);
      check("gap_ram", n, DWELL + 1);
    end

    // Back to CPU view during the dwell.
    serve(1, 0, 1'b1, 1'b0);
    switchFlag = 1'b0;
    wait_req(n);
    check("back_gap", n, 2);
    check("back_page", dbg_reg_addr, 0);
    check("back_view", view_mode, 0);

    // Frame that never completes.
`ifdef LCD_VIEW_SCHED_TIMEOUT_EN
    check("err_before", frame_err, 0);
    n = 0;
    do begin
      @(negedge qzt_clk);
      n++;
    end while (frame_req && n < 100);
    check("timeout_len", n, TMO + 1);
    check("err_set", frame_err, 1);
`else
    repeat (40) @(negedge qzt_clk);
    check("no_timeout_req", frame_req, 1);
    check("no_timeout_err", frame_err, 0);
    frame_done = 1'b1;
    @(negedge qzt_clk);
    frame_done = 1'b0;
`endif
    wait_req(n);
    check("gap_after_hang", n, DWELL + 1);

    // lcd_ready drop keeps the page and restarts from WAIT_READY.
    serve(1, 1, 1'b0, 1'b0);
    page = 1;
    wait_req(n);
    check("gap_step2", n, 2);
    @(negedge qzt_clk);
    lcd_ready = 1'b0;
    @(negedge qzt_clk);
    check("ready_drop_req", frame_req, 0);
    check("ready_drop_page", dbg_reg_addr, 1);
    repeat (3) @(negedge qzt_clk);
    lcd_ready = 1'b1;
    wait_req(n);
    check("ready_gap", n, 2);
    serve(2, 0, 1'b0, 1'b0);
`ifdef LCD_VIEW_SCHED_TIMEOUT_EN
    check("err_sticky", frame_err, 1);
`else
    check("err_tied", frame_err, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lcd_view_scheduler.md
Name: lcd_view_scheduler

Overview:
- Sequences the content shown by the 4-bit debug LCD writer.
- Selects RAM-view (address/data pair) or CPU-view (one byte of the 80-bit CPU debug bus per page) and latches a stable snapshot for each frame.
- Issues a frame request and waits for the writer's completion pulse, then dwells and advances the page.
- Sits between the CPU/RAM debug taps and the LCD writer; drives the writer's dbg_reg_addr, address and data inputs.

Parameters:
- NUM_REGS, 10, number of CPU-view pages; byte k = CPU_interface[8k+7:8k], k = 0..NUM_REGS-1 (max 16).
- DWELL_CYCLES, 12000000, qzt_clk cycles each page stays displayed after frame completion (24-bit counter).
- SYNC_STAGES, 2, flip-flop stages synchronising step_btn.
- TIMEOUT_CYCLES, 2000000, frame watchdog limit (used only with the optional feature; 22-bit counter).

Ports:
- qzt_clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- switchFlag  input  1  1 = RAM view, 0 = CPU view.
- auto_en  input  1  1 = auto-advance CPU page after dwell.
- step_btn  input  1  raw asynchronous push-button; a rising edge advances the page.
- CPU_interface  input  80  CPU debug bus, 10 bytes.
- ram_addr  input  8  RAM-view address tap.
- ram_data  input  8  RAM-view data tap.
- lcd_ready  input  1  writer has finished power-on init; level.
- frame_done  input  1  one-cycle pulse from the writer when a frame has been written.
- dbg_reg_addr  output  4  current CPU page index.
- addrOut  output  8  snapshot address to the writer.
- dataOut  output  8  snapshot data to the writer.
- frame_req  output  1  frame request level.
- view_mode  output  1  switchFlag value latched with the snapshot.
- frame_err  output  1  sticky watchdog flag; held 0 when the optional feature is not compiled in.

Behaviour:
- Reset (async, rst_n=0): state=WAIT_READY; dbg_reg_addr=0; addrOut=0; dataOut=0; frame_req=0; view_mode=0; frame_err=0; dwell counter=0; step synchroniser and pending flag cleared. Reset mid-frame drops frame_req immediately.
- FSM states: WAIT_READY, LATCH, REQ, WAIT_DONE, DWELL.
- WAIT_READY: stay until lcd_ready=1, then LATCH.
- LATCH, 1 cycle:
  - view_mode <= switchFlag.
  - RAM view: addrOut <= ram_addr, dataOut <= ram_data.
  - CPU view: addrOut <= {4'h0, dbg_reg_addr}, dataOut <= byte[dbg_reg_addr].
  - Next state REQ.
- REQ: assert frame_req=1 in the cycle after LATCH; go to WAIT_DONE.
- WAIT_DONE: frame_req stays 1; addrOut, dataOut, view_mode and dbg_reg_addr are frozen. When frame_done=1 is sampled: frame_req <= 0, load the dwell counter, go to DWELL. Request-to-drop latency is exactly 1 cycle after the frame_done pulse.
- DWELL: count down DWELL_CYCLES. At 0, go to LATCH (continuous refresh). Page advances as follows:
  - In CPU view with auto_en=1, dbg_reg_addr advances on the dwell expiry.
  - A pending step advances dbg_reg_addr and goes to LATCH immediately, aborting the dwell.
- Page advance: dbg_reg_addr = NUM_REGS-1 wraps to 0; otherwise +1. Never holds a value >= NUM_REGS.
- step_btn handling:
  - Pass through SYNC_STAGES flip-flops, then rising-edge detect.
  - An edge sets a pending flag; multiple edges before service count as one.
  - The flag is serviced only in DWELL or WAIT_READY, never during WAIT_DONE.
  - Ignored in RAM view (flag cleared).
- switchFlag change while view_mode differs:
  - In WAIT_DONE: wait for frame completion.
  - In DWELL: abort the dwell, set dbg_reg_addr=0, go to LATCH.
- lcd_ready falling in any state: drop frame_req, go to WAIT_READY; dbg_reg_addr is kept.
- frame_done outside WAIT_DONE is ignored.
- Simultaneous dwell expiry and pending step: advance once only, and clear the flag.

Optional Feature:
- Macro: LCD_VIEW_SCHED_TIMEOUT_EN.
- Defined: WAIT_DONE runs a watchdog counter. After TIMEOUT_CYCLES without frame_done, set frame_err=1 (sticky until rst_n), drop frame_req, and go to DWELL as if the frame had completed.
- Undefined: no watchdog counter; WAIT_DONE waits indefinitely; frame_err tied to 0.

Test Plan:
- Reset with rst_n=0 mid-WAIT_DONE -> frame_req=0 asynchronously; all outputs 0; state WAIT_READY until lcd_ready=1.
- CPU view, auto_en=1, DWELL_CYCLES=8, CPU_interface byte 9=8'hA5; pulse frame_done 5 cycles after each frame_req -> dbg_reg_addr steps 0..9 then 0. With dbg_reg_addr=9, dataOut=8'hA5 and addrOut=8'h09. frame_req drops 1 cycle after each frame_done.
- RAM view, ram_addr=8'h3C, ram_data=8'h7E; change the taps to 8'h00 during WAIT_DONE -> addrOut/dataOut hold 3C/7E until the next LATCH, then show 00/00.
- auto_en=0; two step_btn edges during WAIT_DONE -> one advance only, occurring in DWELL right after frame_done, dbg_reg_addr 4->5.
- Toggle switchFlag 0->1 during DWELL with dbg_reg_addr=6 -> dbg_reg_addr=0; LATCH next cycle with view_mode=1.
- With LCD_VIEW_SCHED_TIMEOUT_EN defined and TIMEOUT_CYCLES=16, never pulse frame_done -> frame_err=1 and frame_req=0 after 16 cycles in WAIT_DONE, then DWELL entered. Without the macro -> frame_req stays 1 and frame_err=0.
